// File: rtl/nukv_fifogen_sync.sv
// Single-clock FWFT FIFO with a registered head, occupancy count and registered almost-full.
// Define NUKV_FIFO_PASSTHROUGH_EN to build the legacy zero-depth wire-through stage instead.
module nukv_fifogen_sync #(
    parameter int ADDR_BITS         = 5,
    parameter int DATA_SIZE         = 16,
    parameter int ALMOST_FULL_SLACK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic                 s_axis_talmostfull,
    output logic [DATA_SIZE-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [ADDR_BITS:0]   fifo_count
);

`ifdef NUKV_FIFO_PASSTHROUGH_EN

    assign m_axis_tdata       = s_axis_tdata;
    assign m_axis_tvalid      = s_axis_tvalid;
    assign s_axis_tready      = m_axis_tready;
    assign s_axis_talmostfull = 1'b0;
    assign fifo_count         = '0;

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

`else

    localparam int                 DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AF_LEVEL  = (ADDR_BITS + 1)'(DEPTH - ALMOST_FULL_SLACK);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 afull_q, afull_d;

    logic                 push, pop, load, arr_empty, mem_we;
    logic [ADDR_BITS:0]   arr_count;

    // Space is judged on registered occupancy only, so a same-cycle pop never frees a slot.
    assign s_axis_tready = (count_q != DEPTH_CNT) && !rst;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        push      = s_axis_tvalid && s_axis_tready;
        pop       = out_valid_q && m_axis_tready;
        load      = !out_valid_q || pop;
        arr_count = count_q - {{ADDR_BITS{1'b0}}, out_valid_q};
        arr_empty = (arr_count == '0);
        mem_we    = push;

        if (load) begin
            if (!arr_empty) begin
                out_data_d  = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + ADDR_BITS'(1);
            end else if (push) begin
                // Nothing older is stored: hand the incoming word straight to the head.
                out_data_d  = s_axis_tdata;
                out_valid_d = 1'b1;
                mem_we      = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_BITS + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_BITS + 1)'(1);
            default: count_d = count_q;
        endcase

        afull_d = (count_d >= AF_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            afull_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            afull_q     <= afull_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    assign m_axis_tdata       = out_data_q;
    assign m_axis_tvalid      = out_valid_q;
    assign s_axis_talmostfull = afull_q;
    assign fifo_count         = count_q;

`endif

endmodule

// File: tb/tb_nukv_fifogen_sync.sv
// Directed and randomised checks of nukv_fifogen_sync at default size plus a DEPTH=8, slack=2 instance.
module tb_nukv_fifogen_sync;

    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int SLACK = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [DW-1:0] s_tdata  = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_afull;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [AW:0]   count;

    logic [DW-1:0] sm_s_tdata  = '0;
    logic          sm_s_tvalid = 1'b0;
    logic          sm_s_tready;
    logic          sm_s_afull;
    logic [DW-1:0] sm_m_tdata;
    logic          sm_m_tvalid;
    logic          sm_m_tready = 1'b0;
    logic [3:0]    sm_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    nukv_fifogen_sync #(.ADDR_BITS(AW), .DATA_SIZE(DW), .ALMOST_FULL_SLACK(SLACK)) u_dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_talmostfull(s_afull),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .fifo_count(count)
    );

    nukv_fifogen_sync #(.ADDR_BITS(3), .DATA_SIZE(DW), .ALMOST_FULL_SLACK(2)) u_dut_small (
        .clk(clk), .rst(rst),
        .s_axis_tdata(sm_s_tdata), .s_axis_tvalid(sm_s_tvalid), .s_axis_tready(sm_s_tready),
        .s_axis_talmostfull(sm_s_afull),
        .m_axis_tdata(sm_m_tdata), .m_axis_tvalid(sm_m_tvalid), .m_axis_tready(sm_m_tready),
        .fifo_count(sm_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_state(input string tag);
        int c;
        c = exp_q.size();
        check({tag, ":count"}, 32'(count), c);
        check({tag, ":tvalid"}, 32'(m_tvalid), 32'(c > 0));
        if (c > 0) check({tag, ":tdata"}, 32'(m_tdata), 32'(exp_q[0]));
        check({tag, ":tready"}, 32'(s_tready), 32'(c != DEPTH));
        check({tag, ":afull"}, 32'(s_afull), 32'(c >= DEPTH - SLACK));
    endtask

    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
        logic push, pop;
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
        push = v && (exp_q.size() != DEPTH);
        pop  = r && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(d);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
    endtask

    task automatic sm_cycle(input logic v, input logic [DW-1:0] d, input logic r);
        sm_s_tvalid = v;
        sm_s_tdata  = d;
        sm_m_tready = r;
        @(posedge clk);
        #1;
        sm_s_tvalid = 1'b0;
        sm_m_tready = 1'b0;
    endtask

    initial begin
        logic          v, r;
        logic [DW-1:0] d;

        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", 32'(s_tready), 0);
        check("rst_tvalid", 32'(m_tvalid), 0);
        check("rst_tdata", 32'(m_tdata), 0);
        check("rst_count", 32'(count), 0);
        check("rst_afull", 32'(s_afull), 0);
        check("rst_sm_afull", 32'(sm_s_afull), 0);
        rst = 1'b0;
        #1;
        check("post_rst_tready", 32'(s_tready), 1);

        for (int i = 1; i <= 5; i++) cycle(1'b1, DW'(i), 1'b0);
        check("fill5_count", 32'(count), 5);
        check("fill5_head", 32'(m_tdata), 32'h0001);
        check("fill5_valid", 32'(m_tvalid), 1);
        for (int i = 1; i <= 5; i++) begin
            check("drain_data", 32'(m_tdata), i);
            check("drain_valid", 32'(m_tvalid), 1);
            cycle(1'b0, '0, 1'b1);
        end
        check("drain_count", 32'(count), 0);
        check("drain_empty", 32'(m_tvalid), 0);

        cycle(1'b1, 16'hBEEF, 1'b0);
        check("beef_valid", 32'(m_tvalid), 1);
        check("beef_data", 32'(m_tdata), 32'hBEEF);
        check("beef_count", 32'(count), 1);
        cycle(1'b0, '0, 1'b1);
        check("beef_popped", 32'(m_tvalid), 0);
        check("beef_count0", 32'(count), 0);

        for (int i = 0; i < 6; i++) begin
            sm_cycle(1'b1, DW'(16'h10 + i), 1'b0);
            if (i == 4) begin
                check("sm5_count", 32'(sm_count), 5);
                check("sm5_afull", 32'(sm_s_afull), 0);
            end
        end
        check("sm6_count", 32'(sm_count), 6);
        check("sm6_afull", 32'(sm_s_afull), 1);
        sm_cycle(1'b1, 16'h16, 1'b0);
        sm_cycle(1'b1, 16'h17, 1'b0);
        check("sm_full_count", 32'(sm_count), 8);
        check("sm_full_tready", 32'(sm_s_tready), 0);
        sm_cycle(1'b1, 16'h99, 1'b1);
        check("sm_refused_count", 32'(sm_count), 7);
        check("sm_refused_head", 32'(sm_m_tdata), 32'h11);
        check("sm_refused_tready", 32'(sm_s_tready), 1);
        check("sm_refused_afull", 32'(sm_s_afull), 1);
        for (int i = 1; i <= 7; i++) begin
            check("sm_drain_data", 32'(sm_m_tdata), 32'h10 + i);
            sm_cycle(1'b0, '0, 1'b1);
        end
        check("sm_empty_valid", 32'(sm_m_tvalid), 0);
        check("sm_empty_count", 32'(sm_count), 0);
        check("sm_empty_afull", 32'(sm_s_afull), 0);

        for (int k = 0; k < 10000; k++) begin
            check_state("rand");
            v = ($urandom_range(0, 99) < ((k < 5000) ? 70 : 40));
            r = ($urandom_range(0, 99) < ((k < 5000) ? 40 : 70));
            d = DW'($urandom_range(0, 16'hFFFF));
            cycle(v, d, r);
        end
        for (int k = 0; k < 2 * DEPTH && exp_q.size() > 0; k++) begin
            check_state("rand_drain");
            cycle(1'b0, '0, 1'b1);
        end
        check("rand_drained", 32'(count), 0);

        for (int i = 0; i < 20; i++) cycle(1'b1, DW'(16'h0100 + i), 1'b0);
        check("pre_rst_count", 32'(count), 20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_valid", 32'(m_tvalid), 0);
        check("mid_rst_afull", 32'(s_afull), 0);
        cycle(1'b1, 16'h00AA, 1'b0);
        check("after_rst_data", 32'(m_tdata), 32'h00AA);
        check("after_rst_valid", 32'(m_tvalid), 1);
        check("after_rst_count", 32'(count), 1);
        cycle(1'b0, '0, 1'b1);
        check("after_rst_empty", 32'(m_tvalid), 0);
        check("after_rst_count0", 32'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nukv_fifogen_sync.md
# nukv_fifogen_sync

Single-clock, parametrised synchronous FIFO for AXI-Stream-style valid/ready links inside the NUKV pipeline. It replaces the zero-depth passthrough stage with real buffering of 2^ADDR_BITS words. It provides a registered first-word-fall-through output, an occupancy count and a true almost-full flag that upstream producers use for early back-pressure. It sits between pipeline stages wherever decoupling or elastic buffering is needed.

## Interface
- ADDR_BITS, 5, log2 of capacity; DEPTH = 2^ADDR_BITS words; legal range 1..12.
- DATA_SIZE, 16, payload width in bits.
- ALMOST_FULL_SLACK, 4, almost-full asserts when occupancy >= DEPTH - ALMOST_FULL_SLACK; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset; synchronous, active-high.
- s_axis_tdata  in  DATA_SIZE  write payload.
- s_axis_tvalid  in  1  write request.
- s_axis_tready  out  1  space available; a push is accepted when tvalid && tready.
- s_axis_talmostfull  out  1  occupancy threshold reached.
- m_axis_tdata  out  DATA_SIZE  head-of-FIFO payload, registered.
- m_axis_tvalid  out  1  head valid, registered.
- m_axis_tready  in  1  consumer accepts the head when tvalid && tready.
- fifo_count  out  ADDR_BITS+1  current occupancy, 0..DEPTH, registered.

## Operation
- Storage: DEPTH-entry array plus one output register. Total capacity is exactly DEPTH words. fifo_count includes the word held in the output register.
- Write pointer and read pointer are ADDR_BITS wide and wrap naturally modulo DEPTH. Full and empty are derived from fifo_count, never from pointer equality.
- Push accepted iff s_axis_tvalid && s_axis_tready. Pop occurs iff m_axis_tvalid && m_axis_tready.
- Count update per cycle: push only: +1. Pop only: -1. Both or neither: unchanged.
- s_axis_tready = (fifo_count != DEPTH) && !rst. It is a function of registers only and has no combinational path from m_axis_tready. When full, a push is refused even if a pop happens in the same cycle.
- Output register refill: when the output register is empty or popped, it loads the oldest stored word. If the array is empty and a push occurs, the pushed word is loaded directly (bypass).
- Words leave in strict arrival order. Data is not modified, duplicated or dropped.
- s_axis_talmostfull is registered: next value = (next_count >= DEPTH - ALMOST_FULL_SLACK). With ALMOST_FULL_SLACK = 0 it equals the full condition.
- A push attempted while s_axis_tready = 0 is ignored. The producer must hold data per the valid/ready rules.

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, fifo_count 0, s_axis_talmostfull 0 (1 if DEPTH - ALMOST_FULL_SLACK = 0 is impossible by range), s_axis_tready 0 while rst is high.
- s_axis_tready is 1 on the first cycle after rst deasserts.
- Reset mid-operation discards all contents. Pointers return to 0. No word accepted before reset is ever presented afterwards.
- Latency on an empty FIFO: a word pushed at edge N is presented with m_axis_tvalid = 1 after edge N, so it is poppable at edge N+1.
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH-1.
- fifo_count and s_axis_talmostfull reflect the pushes and pops of edge N immediately after edge N.
- m_axis_tdata and m_axis_tvalid are stable while m_axis_tvalid && !m_axis_tready.

## Configuration
- NUKV_FIFO_PASSTHROUGH_EN defined: the block compiles to pure wires, as the legacy stage did. m_axis_tdata = s_axis_tdata, m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready, s_axis_talmostfull = 0, fifo_count = 0. No storage, zero latency, clk and rst unused.
- Not defined: full buffered FIFO as specified above (default).

## Test plan
- Reset, then push 0x0001..0x0005 one per cycle with m_axis_tready = 0 -> fifo_count = 5, outputs hold 0x0001 with tvalid = 1; release tready -> 0x0001..0x0005 out in order on consecutive cycles, count returns to 0.
- ADDR_BITS = 3, ALMOST_FULL_SLACK = 2: push 6 words with no pops -> talmostfull rises after the 6th push. Push 2 more -> count = 8 and s_axis_tready = 0. A 9th push with concurrent pop is refused and count becomes 7.
- Empty FIFO, single push of 0xBEEF at edge N -> m_axis_tvalid = 1 and tdata = 0xBEEF after edge N. Pop at edge N+1 -> tvalid = 0.
- Continuous push and pop with a random tvalid/tready pattern for 10k cycles, DEPTH = 32 -> scoreboard order matches, no loss, fifo_count always equals pushes minus pops.
- Fill to 20 words, assert rst for 1 cycle mid-stream -> count = 0, tvalid = 0, none of the 20 words appear. The next pushed word 0x00AA is the first word out.
- Compile with NUKV_FIFO_PASSTHROUGH_EN -> m_axis outputs mirror s_axis inputs in the same cycle, s_axis_tready follows m_axis_tready, talmostfull = 0.
